div_iter_unit: RTL and testbench
================================

// Module: div_iter_unit
// PURPOSE
//  Iterative radix-2 restoring divider. It is the multi-cycle responder for div/divu that the decode and execute stages issue.
//  EX holds the start request. The unit returns {hi,lo} = {remainder,quotient} and drives stallreq into the stall controller until the result is ready.
//  It sits beside the ALU in EX. The 64-bit result feeds the hi/lo write path toward the register file.
// PARAMETERS
//  WIDTH  32  operand width in bits. Must be >= 2.
//  CNT_W  6   iteration counter width. Must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous, active-high reset
//  start      in   1          division request; held high by EX until ready
//  div_signed in   1          1 = div (signed), 0 = divu; sampled with start in FREE
//  annul      in   1          cancel the in-flight operation (branch flush / exception)
//  opdata1    in   WIDTH      dividend; sampled in FREE
//  opdata2    in   WIDTH      divisor; sampled in FREE
//  result     out  2*WIDTH    {remainder, quotient}, registered
//  ready      out  1          result valid, registered
//  stallreq   out  1          combinational: start & ~ready & ~annul
// BEHAVIOUR
//  Reset: state=FREE, cnt=0, result=0, ready=0; the working registers are cleared.
//  States:
//   FREE   - idle. If start & ~annul:
//             divisor==0 -> BYZERO;
//             otherwise load |dividend| and |divisor| (unsigned: raw values), save the sign flags, cnt=0 -> ON.
//  BYZERO - next cycle: result=0, ready=1 -> END. The MIPS result is undefined here; the unit defines it as 0.
//  ON     - while cnt<WIDTH: one restoring step per cycle, then cnt++.
//            Step: shift {rem,quo} left by 1, trial = rem - divisor; if trial>=0 then rem=trial and the quotient LSB=1.
//            When cnt==WIDTH: apply the sign fix, register result, ready=1 -> END.
//  END    - hold result and ready while start=1. When start=0: ready=0, result=0 -> FREE.
//  Sign fix (signed only):
//   - Quotient is negated when the operand signs differ.
//   - Remainder takes the sign of the dividend.
//   - Negation is two's complement, WIDTH bits, with wrap. 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
//  Latency: start sampled in FREE at cycle t. ready=1 at t+WIDTH+2 (34 for WIDTH=32). Divide-by-zero: ready at t+2.
//  Handshake:
//   - EX keeps start and the operands stable until ready.
//   - The operands are sampled only in FREE; later changes have no effect.
//   - One cycle after EX drops start, the unit is back in FREE. A new start may be sampled then.
//  Annul:
//   - In ON or BYZERO: next state FREE, ready=0, result=0, no result produced.
//   - In END: treated as start deassert.
//   - In FREE: the start is ignored.
//   - stallreq is 0 in any cycle where annul=1.
//  Simultaneous start & annul in FREE: annul wins; the unit stays in FREE.
//  rst has priority over every other input in every state. The unit returns to FREE within one cycle.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   - In FREE, with divisor!=0 and |dividend| < |divisor| (unsigned compare of the magnitudes), skip ON and go straight to END.
//   - The shortcut registers quotient=0 and remainder=original dividend; ready at t+1.
//  DIV_EARLY_OUT_EN undefined: every nonzero-divisor operation takes the full WIDTH+2 cycles; the comparator is not built.
// TESTING
//  1 Unsigned divide: divu 100/7 -> ready at t+34, result={32'd2,32'd14}; start drops -> ready=0 the next cycle, state FREE.
//  2 Signed divide: div -7/2 (0xFFFFFFF9/0x2) -> result={0xFFFFFFFF,0xFFFFFFFD}; div 7/-2 -> {0x1,0xFFFFFFFD}.
//  3 Divide by zero: divu 5/0 -> ready at t+2, result=0; stallreq=1 for exactly the cycles t..t+1.
//  4 Overflow: div 0x80000000/0xFFFFFFFF -> result={0x0,0x80000000}, no hang.
//  5 Annul and reset mid-operation:
//    - annul at t+10 -> stallreq=0 that cycle, no ready, FREE at t+11; a following divu 9/3 -> {0,3}.
//    - rst at t+5 -> all outputs 0 the next cycle.
//  6 Early out: divu 3/5.
//    - With DIV_EARLY_OUT_EN -> ready at t+1, result={3,0}.
//    - Without it -> ready at t+34 with the same result.

Source files
------------

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - request/response bundle between EX and the iterative divider
//
// Purpose: groups the divide request (start, operands, signedness, annul) and
// the divider response (result, ready, stallreq) so EX and the divider share
// one port.
//
// Signals:
//   start       EX -> div   division request, held until ready
//   div_signed  EX -> div   1 = div (signed), 0 = divu
//   annul       EX -> div   cancel the in-flight operation
//   opdata1     EX -> div   dividend
//   opdata2     EX -> div   divisor
//   result      div -> EX   {remainder, quotient}
//   ready       div -> EX   result valid
//   stallreq    div -> EX   pipeline stall request
//
// Modports: master (EX side), slave (divider side).

interface div_iter_unit_if #(
  parameter int WIDTH = 32
) ();

  logic               start;
  logic               div_signed;
  logic               annul;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stallreq;

  modport master (
    output start, div_signed, annul, opdata1, opdata2,
    input  result, ready, stallreq
  );

  modport slave (
    input  start, div_signed, annul, opdata1, opdata2,
    output result, ready, stallreq
  );

endinterface

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative radix-2 restoring divider for div/divu
//
// Purpose: multi-cycle divider beside the ALU in EX. Divides operand
// magnitudes one quotient bit per cycle, then applies the sign fix and
// returns {remainder, quotient}. Holds stallreq while a request is pending.
//
// Ports:
//   clk   in  clock
//   rst   in  synchronous, active-high reset
//   bus   div_iter_unit_if.slave
//           start/div_signed/annul/opdata1/opdata2 in,
//           result (registered), ready (registered), stallreq (combinational) out
//
// Parameters:
//   WIDTH  operand width (>= 2)
//   CNT_W  iteration counter width (2**CNT_W > WIDTH)
//
// Configuration macro: DIV_EARLY_OUT_EN
//   defined   - when |dividend| < |divisor| the result is produced straight
//               from FREE (quotient 0, remainder = dividend), ready next cycle.
//   undefined - every nonzero-divisor operation runs all WIDTH steps and the
//               magnitude comparator is not built.

module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  div_iter_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  // Working registers: partial remainder, dividend/quotient shift register,
  // divisor magnitude, and the two sign flags for the final fix-up.
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_quo_q;
  logic               neg_rem_q;

  // ------------------------------------------------------------------
  // Operand magnitudes (only meaningful while sampled in FREE)
  // ------------------------------------------------------------------
  logic               dvd_neg;
  logic               dvs_neg;
  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic               divisor_zero;
  logic               early_out;

  assign dvd_neg      = bus.div_signed & bus.opdata1[WIDTH-1];
  assign dvs_neg      = bus.div_signed & bus.opdata2[WIDTH-1];
  assign dvd_abs      = dvd_neg ? (~bus.opdata1 + 1'b1) : bus.opdata1;
  assign dvs_abs      = dvs_neg ? (~bus.opdata2 + 1'b1) : bus.opdata2;
  assign divisor_zero = (bus.opdata2 == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (dvd_abs < dvs_abs);
`else
  assign early_out = 1'b0;
`endif

  // ------------------------------------------------------------------
  // One restoring step
  // ------------------------------------------------------------------
  // The shifted partial remainder needs WIDTH+1 bits: rem < divisor can be as
  // large as 2**WIDTH-2, so after the shift its top bit may be set. When the
  // trial subtraction succeeds the difference is < divisor and fits WIDTH bits,
  // so a WIDTH-bit subtract of the low bits is exact.
  logic [WIDTH:0]     shifted;
  logic               take;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign take     = (shifted >= {1'b0, dvs_q});
  assign diff     = shifted[WIDTH-1:0] - dvs_q;
  assign rem_step = take ? diff : shifted[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], take};

  // ------------------------------------------------------------------
  // Sign fix-up, two's complement with wrap (so -2**(W-1) / -1 wraps back
  // to -2**(W-1) with remainder 0)
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FREE;
      cnt       <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          // annul beats a simultaneous start
          if (bus.start && !bus.annul) begin
            if (divisor_zero) begin
              state <= S_BYZERO;
            end else if (early_out) begin
              result_q <= {bus.opdata1, {WIDTH{1'b0}}};
              ready_q  <= 1'b1;
              state    <= S_END;
            end else begin
              rem_q     <= '0;
              quo_q     <= dvd_abs;
              dvs_q     <= dvs_abs;
              neg_quo_q <= dvd_neg ^ dvs_neg;
              neg_rem_q <= dvd_neg;
              cnt       <= '0;
              state     <= S_ON;
            end
          end
        end

        S_BYZERO: begin
          // Architecturally undefined result; this unit returns 0.
          result_q <= '0;
          if (bus.annul) begin
            ready_q <= 1'b0;
            state   <= S_FREE;
          end else begin
            ready_q <= 1'b1;
            state   <= S_END;
          end
        end

        S_ON: begin
          if (bus.annul) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            cnt      <= '0;
            state    <= S_FREE;
          end else if (cnt != CNT_W'(WIDTH)) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt   <= cnt + 1'b1;
          end else begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            cnt      <= '0;
            state    <= S_END;
          end
        end

        S_END: begin
          // An annul here is just an early release of start.
          if (!bus.start || bus.annul) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            state    <= S_FREE;
          end
        end

        default: begin
          result_q <= '0;
          ready_q  <= 1'b0;
          state    <= S_FREE;
        end
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.ready    = ready_q;
  assign bus.stallreq = bus.start & ~ready_q & ~bus.annul;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - self-checking bench for div_iter_unit

module tb_div_iter_unit;

  localparam int W = 32;
  localparam int TIMEOUT = 100;

  logic clk;
  logic rst;

  div_iter_unit_if #(.WIDTH(W)) bus ();

  div_iter_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic int lat_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(a, s) < mag(b, s)) return 1;
`endif
    return W + 2;
  endfunction

  // Reference model for random vectors.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) return '0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.div_signed = 1'b0;
    bus.annul      = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
  endtask

  // Issue one request, scoreboard the expectation, wait for ready, release.
  task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] exp);
    sb_t e;
    sb_t got;
    int  k;
    logic stall_ok;
    e.res = exp;
    e.lat = lat_of(a, b, s);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.div_signed = s; bus.opdata1 = a; bus.opdata2 = b;
    sb_q.push_back(e);
    #1;
    stall_ok = bus.stallreq;
    k = 0;
    while (k < TIMEOUT) begin
      @(posedge clk); #2;
      k++;
      if (bus.ready) break;
      if (!bus.stallreq) stall_ok = 1'b0;
      // Operands are sampled only in FREE; later changes must not matter.
      if (k == 3) begin
        bus.opdata1 = ~a;
        bus.opdata2 = b + 1;
      end
    end
    if (!bus.ready) begin
      check({name, " timeout"}, 64'(k), 64'(e.lat));
      void'(sb_q.pop_front());
      idle_inputs();
      return;
    end
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd0, 64'd1);
      return;
    end
    got = sb_q.pop_front();
    check({name, " result"}, bus.result, got.res);
    check({name, " latency"}, 64'(k), 64'(got.lat));
    check({name, " stall while busy"}, 64'(stall_ok), 64'd1);
    check({name, " stall at ready"}, 64'(bus.stallreq), 64'd0);
    bus.start = 1'b0;
    @(posedge clk); #2;
    check({name, " ready after release"}, 64'(bus.ready), 64'd0);
    check({name, " result after release"}, bus.result, 64'd0);
    idle_inputs();
  endtask

  vec_t vecs[14];

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           k;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, {32'd2,          32'd14}};
    vecs[1]  = '{32'hFFFFFFF9,   32'h2,          1'b1, {32'hFFFFFFFF,   32'hFFFFFFFD}};
    vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, {32'h1,          32'hFFFFFFFD}};
    vecs[3]  = '{32'd5,          32'd0,          1'b0, 64'd0};
    vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0,          32'h80000000}};
    vecs[5]  = '{32'd9,          32'd3,          1'b0, {32'd0,          32'd3}};
    vecs[6]  = '{32'd3,          32'd5,          1'b0, {32'd3,          32'd0}};
    vecs[7]  = '{32'hFFFFFFFF,   32'd1,          1'b0, {32'd0,          32'hFFFFFFFF}};
    vecs[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, {32'd0,          32'd1}};
    vecs[9]  = '{32'hFFFFFF9C,   32'd7,          1'b1, {32'hFFFFFFFE,   32'hFFFFFFF2}};
    vecs[10] = '{32'h80000000,   32'd2,          1'b0, {32'd0,          32'h40000000}};
    vecs[11] = '{32'hFFFFFFFB,   32'd0,          1'b1, 64'd0};
    vecs[12] = '{32'hFFFFFFFD,   32'd5,          1'b1, {32'hFFFFFFFD,   32'd0}};
    vecs[13] = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, {32'hFFFFFFFF,   32'd3}};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset result", bus.result, 64'd0);
    check("reset stallreq", 64'(bus.stallreq), 64'd0);

    for (int i = 0; i < 14; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = $urandom() >> $urandom_range(0, 28);
      rs = 1'(i & 1);
      if (rb == 0) rb = 32'd11;
      run_vec($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs));
    end

    // Annul mid-operation: stallreq drops that cycle, no result ever appears.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    k = 0;
    repeat (10) begin @(posedge clk); #2; k++; end
    bus.annul = 1'b1;
    #1;
    check("annul stallreq", 64'(bus.stallreq), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("annul ready", 64'(bus.ready), 64'd0);
    repeat (40) begin
      @(posedge clk); #2;
      if (bus.ready) break;
    end
    check("annul no late ready", 64'(bus.ready), 64'd0);
    run_vec("after annul 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

    // Start and annul together in FREE: request ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd8; bus.opdata2 = 32'd0;
    #1;
    check("start+annul stallreq", 64'(bus.stallreq), 64'd0);
    repeat (4) @(posedge clk);
    #2;
    check("start+annul ready", 64'(bus.ready), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    run_vec("after start+annul 8/2", 32'd8, 32'd2, 1'b0, {32'd0, 32'd4});

    // Reset mid-operation.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opdata1 = 32'd77; bus.opdata2 = 32'd4;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst mid ready", 64'(bus.ready), 64'd0);
    check("rst mid result", bus.result, 64'd0);
    check("rst mid stallreq", 64'(bus.stallreq), 64'd0);
    run_vec("after rst 77/4", 32'd77, 32'd4, 1'b0, {32'd1, 32'd19});

    // Annul while holding a result in END releases it.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.opdata1 = 32'd6; bus.opdata2 = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check("end hold ready", 64'(bus.ready), 64'd1);
    bus.annul = 1'b1;
    @(posedge clk); #2;
    check("end annul ready", 64'(bus.ready), 64'd0);
    idle_inputs();

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
